fnd_scan_driver: RTL and testbench
==================================

Name: fnd_scan_driver

Overview:
- Time-multiplexed 4-digit common-anode 7-segment (FND) driver; consumes the 4-bit digit outputs of the up/down/BCD counter stages, packed as a 16-bit value.
- Rotates the digit strobe on a divided clock tick and drives the matching segment pattern.
- Snapshots the input once per full scan frame so a counter update cannot tear a frame.
- Sits directly between the counter blocks and the board's FND pins.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2.
- DIV_W, 17: width of the scan divider counter; must satisfy 2^DIV_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_p  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- enable  input  1  1 = scanning; 0 = display dark and scan frozen.
- value  input  16  four nibbles; value[3:0] = digit 0 (rightmost) … value[15:12] = digit 3.
- dp_mask  input  4  per-digit decimal-point request; bit i lights the DP of digit i.
- com  output  4  digit strobes, active-low; com[i]=0 selects digit i.
- seg_7  output  8  segments, active-low; [0]=a,[1]=b,…,[6]=g,[7]=dp.

Behaviour:
- Reset (reset_p=1 at a clk edge):
  - div_cnt=0, idx=0, snap=16'h0000, snap_dp=4'b0000.
  - com=4'b1111, seg_7=8'hFF.
  - Takes priority over every other event, including mid-frame.
- Divider, when enable=1:
  - div_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - tick is asserted combinationally while div_cnt==SCAN_DIV-1.
- Digit index:
  - On tick, idx advances 0→1→2→3→0 (2-bit wrap).
  - idx does not move without a tick.
- Frame snapshot:
  - On the tick where idx==3, so that idx wraps to 0 on the same edge: snap<=value and snap_dp<=dp_mask.
  - value and dp_mask are otherwise ignored.
  - After reset, the first frame displays 0000 with no DPs.
- Output stage (registered, 1-cycle latency from idx/snap):
  - com <= one-cold of idx, e.g. idx=2 → 4'b1011.
  - seg_7[6:0] <= glyph(snap nibble selected by idx).
  - seg_7[7] <= ~snap_dp[idx].
  - Exactly one com bit is low at any time while enabled and out of reset; never two.
- Glyph table (seg_7[6:0], active-low), full hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - With DP off, the full seg_7 byte is C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
- enable=0:
  - div_cnt, idx, snap and snap_dp hold their values.
  - Next edge: com=4'b1111, seg_7=8'hFF.
  - When enable returns to 1, scanning resumes from the held div_cnt/idx; the first lit output appears one cycle later.
- value changing mid-frame: no visible effect until the next frame boundary.
- value changing on the boundary tick: the value present at that edge is captured.

Optional Feature:
- Macro: FND_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i (i=3,2,1) is blanked (seg_7[6:0]=7'h7F) when snap nibble i and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - The DP of a blanked digit still follows snap_dp.
  - com still strobes the blanked digit, so scan timing is unchanged.
- Not defined: all four digits always show their glyph; no blanking logic is synthesised.

Test Plan:
- Sim uses SCAN_DIV=4.
- Reset/idle: hold reset_p 3 cycles, then release with value=16'h1234, enable=1 → com=1110, seg_7=C0 (snap=0) for the first 4 slots. After the wrap tick: com=1110, seg_7=99 ('4'), then 1101/B0, 1011/A4, 0111/F9 every 4 cycles.
- Hex glyphs + DP: value=16'hABCF, dp_mask=4'b0100 → across one frame, digit0=8E, digit1=C6, digit2=03 (0x83 with DP on → 8'h03), digit3=88.
- Tear-free snapshot: change value from 16'h1111 to 16'h9999 while idx=1 → remaining digits of the current frame show F9; all digits show 90 from the next frame.
- Enable gating: drop enable at idx=2, div_cnt=1 for 10 cycles → com=1111, seg_7=FF for cycles 2..11. Re-enable → idx=2 resumes and the tick occurs 3 cycles after re-enable.
- Mid-frame reset: assert reset_p for 1 cycle at idx=3 → next edge com=1111, seg_7=FF, idx=0, snap=0; the following frame displays 0000.
- Leading-zero blank (macro on): value=16'h0070 → digit3=FF, digit2=FF, digit1=F8, digit0=C0. value=16'h0000 → only digit0 lit (C0).

Source files
------------

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: time-multiplexed 4-digit common-anode 7-segment driver.
// A divider produces one tick per digit slot, the tick rotates the digit
// index, and the input value is snapshotted once per full frame so a
// counter update never tears a displayed frame. Outputs are registered.
// Optional feature macro: FND_LEADING_ZERO_BLANK_EN blanks leading zero
// digits (digit 0 is always shown).
module fnd_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  com,
    output logic [7:0]  seg_7
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic [1:0]       idx_r;
    logic [15:0]      snap_r;
    logic [3:0]       snap_dp_r;
    logic [3:0]       com_r;
    logic [7:0]       seg_r;
    logic             tick_s;
    logic [3:0]       nib_s;
    logic [6:0]       glyph_s;
    logic             blank_s;

    // Active-low glyph for one hex nibble, segment a in bit 0.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Active-low strobe with only the selected digit pulled low.
    function automatic logic [3:0] one_cold(input logic [1:0] i);
        logic [3:0] c;
        case (i)
            2'd0:    c = 4'b1110;
            2'd1:    c = 4'b1101;
            2'd2:    c = 4'b1011;
            2'd3:    c = 4'b0111;
            default: c = 4'b1111;
        endcase
        return c;
    endfunction

`ifdef FND_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every higher nibble are zero.
    function automatic logic lead_zero(input logic [15:0] s, input logic [1:0] i);
        logic z;
        case (i)
            2'd3:    z = (s[15:12] == 4'h0);
            2'd2:    z = (s[15:8] == 8'h00);
            2'd1:    z = (s[15:4] == 12'h000);
            default: z = 1'b0;
        endcase
        return z;
    endfunction
`endif

    // Slot boundary: last cycle of the current digit slot.
    always_comb begin
        tick_s = (div_cnt_r == DIV_LAST);
    end

    // Select the snapshot nibble for the current digit and form its glyph.
    always_comb begin
        nib_s = 4'h0;
        case (idx_r)
            2'd0:    nib_s = snap_r[3:0];
            2'd1:    nib_s = snap_r[7:4];
            2'd2:    nib_s = snap_r[11:8];
            2'd3:    nib_s = snap_r[15:12];
            default: nib_s = 4'h0;
        endcase
        glyph_s = hex_glyph(nib_s);
`ifdef FND_LEADING_ZERO_BLANK_EN
        blank_s = lead_zero(snap_r, idx_r);
`else
        blank_s = 1'b0;
`endif
    end

    // Scan divider: counts cycles within a digit slot, frozen while disabled.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            div_cnt_r <= '0;
        end else if (enable) begin
            if (tick_s) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

    // Digit index: advances one digit per slot tick, 2-bit wrap.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            idx_r <= 2'd0;
        end else if (enable && tick_s) begin
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Frame snapshot: capture value/dp_mask on the tick that wraps idx to 0.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            snap_r    <= 16'h0000;
            snap_dp_r <= 4'b0000;
        end else if (enable && tick_s && (idx_r == 2'd3)) begin
            snap_r    <= value;
            snap_dp_r <= dp_mask;
        end else begin
            snap_r    <= snap_r;
            snap_dp_r <= snap_dp_r;
        end
    end

    // Output stage: strobe and segment pattern for the current digit, dark when disabled.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            com_r <= 4'b1111;
            seg_r <= 8'hFF;
        end else if (enable) begin
            com_r <= one_cold(idx_r);
            seg_r <= {~snap_dp_r[idx_r], (blank_s ? 7'h7F : glyph_s)};
        end else begin
            com_r <= 4'b1111;
            seg_r <= 8'hFF;
        end
    end

    assign com   = com_r;
    assign seg_7 = seg_r;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver with SCAN_DIV=4. The model counts
// enabled cycles since reset and derives digit index, frame boundary and
// expected segment byte arithmetically from that count.
module tb_fnd_scan_driver;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    localparam logic [7:0] TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk;
    logic        reset_p;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  com;
    logic [7:0]  seg_7;

    int          n_total;
    int          n_pass;
    int          pos;
    logic [15:0] snap_m;
    logic [3:0]  sdp_m;
    logic        mvalid;

    fnd_scan_driver #(.SCAN_DIV(SD), .DIV_W(3)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .enable  (enable),
        .value   (value),
        .dp_mask (dp_mask),
        .com     (com),
        .seg_7   (seg_7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: com/seg got %h, expected %h (pos=%0d)", name, act, exp, pos);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: predict the output of this edge from the model, advance the
    // model, then compare the DUT after the edge.
    task automatic step();
        logic [3:0]  ec;
        logic [7:0]  es;
        logic [3:0]  nib;
        int          d;
        if (reset_p) begin
            ec = 4'b1111; es = 8'hFF;
            pos = 0; snap_m = 16'h0000; sdp_m = 4'b0000; mvalid = 1'b1;
        end else if (!enable) begin
            ec = 4'b1111; es = 8'hFF;
        end else begin
            d   = (pos / SD) % 4;
            ec  = ~(4'b0001 << d);
            nib = 4'(snap_m >> (4 * d));
            es  = {~sdp_m[d], TBL[nib][6:0]};
`ifdef FND_LEADING_ZERO_BLANK_EN
            if (d > 0 && (snap_m >> (4 * d)) == 16'h0000) es[6:0] = 7'h7F;
`endif
            if (pos % FRAME == FRAME - 1) begin
                snap_m = value;
                sdp_m  = dp_mask;
            end
            pos++;
        end
        @(posedge clk);
        #1;
        if (mvalid) chk("scan", {com, seg_7}, {ec, es});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance at least one cycle, until the enabled-cycle count hits off mod FRAME.
    task automatic align(input int off);
        step();
        for (int i = 0; i < 2 * FRAME && (pos % FRAME) != off; i++) step();
    endtask

    initial begin
        logic [7:0] lz_d3;
        n_total = 0; n_pass = 0; pos = 0;
        snap_m = 16'h0000; sdp_m = 4'b0000; mvalid = 1'b0;
        reset_p = 1'b1; enable = 1'b0; value = 16'h0000; dp_mask = 4'b0000;

        // Reset held three cycles.
        steps(3);
        chk("reset_dark", {com, seg_7}, {4'b1111, 8'hFF});

        // Release: first frame shows 0000, then 1234 from the wrap tick.
        reset_p = 1'b0; enable = 1'b1; value = 16'h1234;
        step();
        chk("first_slot", {com, seg_7}, {4'b1110, 8'hC0});
        steps(15);
        step();
        chk("frame1_d0", {com, seg_7}, {4'b1110, 8'h99});
        steps(4);
        chk("frame1_d1", {com, seg_7}, {4'b1101, 8'hB0});

        // Hex glyphs with a decimal point on digit 2.
        value = 16'hABCF; dp_mask = 4'b0100;
        align(0);
        steps(9);
        chk("hex_d2_dp", {com, seg_7}, {4'b1011, 8'h03});
        steps(4);
        chk("hex_d3", {com, seg_7}, {4'b0111, 8'h88});

        // Enable gating at idx=2, div_cnt=1 for 10 cycles.
        align(9);
        enable = 1'b0;
        step();
        chk("gate_dark", {com, seg_7}, {4'b1111, 8'hFF});
        steps(9);
        enable = 1'b1;
        step();
        chk("gate_resume", {com, seg_7}, {4'b1011, 8'h03});
        steps(3);
        chk("gate_tick", {com, seg_7}, {4'b0111, 8'h88});

        // Tear-free snapshot: change value while idx=1.
        value = 16'h1111; dp_mask = 4'b0000;
        align(0);
        steps(5);
        value = 16'h9999;
        steps(11);
        chk("tear_old", {com, seg_7}, {4'b0111, 8'hF9});
        step();
        chk("tear_new", {com, seg_7}, {4'b1110, 8'h90});

        // Mid-frame reset at idx=3.
        align(12);
        reset_p = 1'b1;
        step();
        chk("midreset_dark", {com, seg_7}, {4'b1111, 8'hFF});
        reset_p = 1'b0;
        step();
        chk("midreset_zero", {com, seg_7}, {4'b1110, 8'hC0});
        steps(15);

        // Leading-zero frames (blanked only with the feature macro).
        value = 16'h0070;
        align(0);
        steps(13);
`ifdef FND_LEADING_ZERO_BLANK_EN
        lz_d3 = 8'hFF;
`else
        lz_d3 = 8'hC0;
`endif
        chk("lz_d3", {com, seg_7}, {4'b0111, lz_d3});
        value = 16'h0000;
        align(0);
        steps(FRAME);

        // A couple of mixed frames with all DPs.
        value = 16'h5E6D; dp_mask = 4'b1111;
        align(0);
        steps(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
